// File: rtl/dbus_ctrl_pkg.sv
// Types shared by the data-bus controller and its posted-write buffer.
package dbus_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Posted-write buffer: synchronous FIFO of {addr, data} entries with registered count.
module wb_fifo
    import dbus_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           Nrst,
    input  logic           push,
    input  wb_entry_t      push_entry,
    input  logic           pop,
    output wb_entry_t      head,
    output logic [PTR_W:0] count,
    output logic           full,
    output logic           empty
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is not reset; an entry is only ever read while count marks it valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    // NOTE: registered state always uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dbus_ctrl.sv
// Data-bus controller: posts stores into a write buffer, drains it, then issues loads in order.
module dbus_ctrl
    import dbus_ctrl_pkg::*;
#(
    parameter int WB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              Nrst,
    input  logic [ADDR_W-1:0] busaddr,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rw_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_empty
);

    localparam int CNT_W = $clog2(WB_DEPTH) + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] RDREQ  = 2'd2;
    localparam logic [1:0] RDDONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] raddr;
    wb_entry_t         push_entry;
    wb_entry_t         head;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drain_done;

    // A simultaneous read and write is resolved as a read; fullness uses the registered count.
    assign push       = (state == IDLE) & wr_req & ~rd_req & ~full;
    assign pop        = mem_wr & mem_ack;
    assign drain_done = empty | ((count == CNT_W'(1)) & pop);
    assign push_entry = '{addr: busaddr, data: wr_data};

    wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
        .clk        (clk),
        .Nrst       (Nrst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        rw_wait   = 1'b1;
        case (state)
            IDLE: begin
                rw_wait = rd_req | (wr_req & full);
                if (rd_req) state_nxt = empty ? RDREQ : DRAIN;
            end
            DRAIN:   if (drain_done) state_nxt = RDREQ;
            RDREQ:   if (mem_ack) state_nxt = RDDONE;
            RDDONE: begin
                rw_wait   = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            state   <= IDLE;
            raddr   <= '0;
            rd_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && rd_req)   raddr   <= busaddr;
            if (state == RDREQ && mem_ack) rd_data <= mem_rdata;
        end
    end

    // External port depends only on state and registered buffer contents.
    assign mem_rd    = (state == RDREQ);
    assign mem_wr    = ~empty & (state != RDREQ);
    assign mem_addr  = mem_rd ? raddr : (mem_wr ? head.addr : '0);
    assign mem_wdata = mem_wr ? head.data : '0;
    assign wb_empty  = empty;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Scoreboard bench for dbus_ctrl: program-order memory reference model plus a random-latency memory.
module tb_dbus_ctrl;

    localparam int WB_DEPTH = 4;
    localparam int TMO      = 200;

    logic        clk = 1'b0;
    logic        Nrst;
    logic [31:0] busaddr;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rw_wait;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_empty;

    always #5 clk = ~clk;

    dbus_ctrl #(.WB_DEPTH(WB_DEPTH)) dut (
        .clk       (clk),
        .Nrst      (Nrst),
        .busaddr   (busaddr),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rw_wait   (rw_wait),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .wb_empty  (wb_empty)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          n_vec = 0;
    int          n_err = 0;
    wr_t         exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] ext_mem[logic [31:0]];
    bit          ack_en = 1'b1;
    int          fixed_delay = 0;   // negative selects a random 0..3 wait
    bit          mm_busy = 1'b0;
    int          mm_wait = 0;
    bit          prev_rd = 1'b0;
    wr_t         mon_e;
    logic [31:0] mon_d;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name, input string what);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // External memory: acks each strobe after a chosen number of wait cycles.
    initial begin : mem_model
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (!Nrst) begin
                mm_busy = 1'b0;
            end else if ((mem_rd || mem_wr) && ack_en) begin
                if (!mm_busy) begin
                    mm_busy = 1'b1;
                    mm_wait = (fixed_delay < 0) ? int'($urandom_range(0, 3)) : fixed_delay;
                end
                if (mm_wait == 0) begin
                    mem_ack = 1'b1;
                    mm_busy = 1'b0;
                    if (mem_wr) ext_mem[mem_addr] = mem_wdata;
                    else mem_rdata = ext_mem.exists(mem_addr) ? ext_mem[mem_addr] : init_val(mem_addr);
                end else begin
                    mm_wait--;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (Nrst) begin
                if (mem_wr && mem_ack) begin
                    if (exp_wr_q.size() == 0) begin
                        fail_note("wr_unexpected", $sformatf("write 0x%08h to 0x%08h, expected none", mem_wdata, mem_addr));
                    end else begin
                        mon_e = exp_wr_q.pop_front();
                        check("wr_addr", mem_addr, mon_e.addr);
                        check("wr_wdata", mem_wdata, mon_e.data);
                    end
                end
                if (mem_rd && !prev_rd) check("rd_order_pending_writes", exp_wr_q.size(), 0);
                if (mem_rd) check("strobe_excl", {31'd0, mem_wr}, 32'd0);
                if (rd_req && !rw_wait) begin
                    if (exp_rd_q.size() == 0) begin
                        fail_note("rd_unexpected", $sformatf("load data 0x%08h, expected no load", rd_data));
                    end else begin
                        mon_d = exp_rd_q.pop_front();
                        check("rd_data", rd_data, mon_d);
                    end
                end
            end
            prev_rd = mem_rd;
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int waits);
        busaddr = a;
        wr_data = d;
        wr_req  = 1'b1;
        waits   = 0;
        @(negedge clk);
        while (rw_wait && waits <= TMO) begin
            waits++;
            @(negedge clk);
        end
        if (waits > TMO) begin
            fail_note("store_accept", "rw_wait never dropped, expected store acceptance");
        end else begin
            exp_wr_q.push_back('{addr: a, data: d});
            ref_mem[a] = d;
        end
        next_cyc();
        wr_req = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output int waits);
        busaddr = a;
        rd_req  = 1'b1;
        waits   = 0;
        exp_rd_q.push_back(ref_read(a));
        @(negedge clk);
        while (rw_wait && waits <= TMO) begin
            waits++;
            @(negedge clk);
        end
        if (waits > TMO) begin
            fail_note("load_done", "rw_wait never dropped, expected load completion");
            void'(exp_rd_q.pop_back());
        end
        next_cyc();
        rd_req = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        @(negedge clk);
        while (!wb_empty && cyc <= TMO) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc > TMO) fail_note("drain", "wb_empty never rose, expected buffer to drain");
        next_cyc();
    endtask

    initial begin : stim
        int          w;
        int          w5;
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;

        Nrst    = 1'b0;
        busaddr = '0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        wr_data = '0;

        // Reset values
        #2;
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_wb_empty", {31'd0, wb_empty}, 32'd1);
        check("rst_rw_wait_idle", {31'd0, rw_wait}, 32'd0);
        rd_req = 1'b1;
        #1;
        check("rst_rw_wait_follows_rd_req", {31'd0, rw_wait}, 32'd1);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        Nrst = 1'b1;
        next_cyc();

        // Single store, zero-wait memory
        fixed_delay = 0;
        do_store(32'h100, 32'hDEAD_BEEF, w);
        check("st_rw_wait_cycles", w, 0);
        @(negedge clk);
        check("st_mem_wr", {31'd0, mem_wr}, 32'd1);
        check("st_mem_addr", mem_addr, 32'h100);
        check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        next_cyc();
        @(negedge clk);
        check("st_wb_empty_after_ack", {31'd0, wb_empty}, 32'd1);
        next_cyc();

        // Buffer full: fifth store stalls until the cycle after the first ack
        ack_en = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            do_store(32'h400 + 32'(4 * i), $urandom, w);
            check("full_accept_wait", w, 0);
        end
        check("full_wb_empty", {31'd0, wb_empty}, 32'd0);
        fork
            do_store(32'h410, $urandom, w5);
            begin
                repeat (3) @(negedge clk);
                ack_en = 1'b1;
            end
        join
        check("full_stall_cycles", w5, 4);
        wait_drain();

        // Load after stores: the read must wait for both writes
        fixed_delay = -1;
        do_store(32'h200, $urandom, w);
        do_store(32'h204, $urandom, w);
        do_load(32'h204, w);
        wait_drain();

        // Load, zero-wait and 3 wait states
        fixed_delay = 0;
        do_load(32'h180, w);
        check("ld_zero_wait_cycles", w, 2);
        ext_mem[32'h300] = 32'h1234_5678;
        ref_mem[32'h300] = 32'h1234_5678;
        fixed_delay = 3;
        do_load(32'h300, w);
        check("ld_wait_state_cycles", w, 5);

        // Simultaneous rd_req and wr_req acts as a read only
        fixed_delay = 0;
        wr_req  = 1'b1;
        wr_data = 32'hBAD0_BAD0;
        do_load(32'h208, w);
        wr_req = 1'b0;

        // Pointer wrap: ten stores, random ack latency
        fixed_delay = -1;
        for (int i = 0; i < 10; i++) begin
            do_store(32'h600 + 32'(4 * $urandom_range(0, 15)), $urandom, w);
        end

        // Random mix of loads and stores over a small address window
        for (int i = 0; i < 40; i++) begin
            a = 32'h700 + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) do_load(a, w);
            else do_store(a, $urandom, w);
        end
        wait_drain();

        // Reset with buffered writes pending: they are discarded
        ack_en = 1'b0;
        do_store(32'h800, $urandom, w);
        do_store(32'h804, $urandom, w);
        @(negedge clk);
        #2;
        Nrst = 1'b0;
        #1;
        check("rst_wr_mem_wr_drop", {31'd0, mem_wr}, 32'd0);
        check("rst_wr_wb_empty", {31'd0, wb_empty}, 32'd1);
        check("rst_wr_mem_addr", mem_addr, 32'd0);
        exp_wr_q.delete();
        ref_mem.delete(32'h800);
        ref_mem.delete(32'h804);
        repeat (2) @(negedge clk);
        Nrst   = 1'b1;
        ack_en = 1'b1;
        next_cyc();

        // Reset while the read is on the bus
        ack_en  = 1'b0;
        busaddr = 32'h500;
        rd_req  = 1'b1;
        cyc     = 0;
        @(negedge clk);
        while (!mem_rd && cyc <= TMO) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc > TMO) fail_note("rst_rd_reach_rdreq", "mem_rd never rose, expected a read strobe");
        #2;
        Nrst = 1'b0;
        #1;
        check("rst_rd_mem_rd_drop", {31'd0, mem_rd}, 32'd0);
        check("rst_rd_wb_empty", {31'd0, wb_empty}, 32'd1);
        check("rst_rd_rw_wait", {31'd0, rw_wait}, 32'd1);
        rd_req = 1'b0;
        #1;
        check("rst_rd_rw_wait_released", {31'd0, rw_wait}, 32'd0);
        repeat (2) @(negedge clk);
        Nrst   = 1'b1;
        ack_en = 1'b1;
        next_cyc();
        @(negedge clk);
        check("post_rst_idle_rw_wait", {31'd0, rw_wait}, 32'd0);
        check("post_rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        next_cyc();

        // Normal operation resumes after reset
        fixed_delay = -1;
        do_store(32'h500, $urandom, w);
        do_load(32'h500, w);
        wait_drain();

        check("wr_queue_left", exp_wr_q.size(), 0);
        check("rd_queue_left", exp_rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dbus_ctrl.md
# dbus_ctrl

Data-bus controller directly downstream of the Memory pipeline stage. It accepts the stage's load/store requests (`busaddr`, `rd_req`, `wr_req`, `wr_data`) and answers with `rw_wait`/`rd_data`. Stores are posted into a small write buffer so the pipeline does not stall on them. Loads wait for the buffer to drain, which preserves program order, and are then issued to the external memory port.

## Interface
- `WB_DEPTH`, default 4: write-buffer entries; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `Nrst`  in  1  reset, asynchronous, active-low.
- `busaddr`  in  32  word-aligned address from the Memory stage; held stable while `rw_wait`=1.
- `rd_req`  in  1  load request; held until a cycle with `rw_wait`=0.
- `wr_req`  in  1  store request; held until a cycle with `rw_wait`=0.
- `wr_data`  in  32  store data.
- `rd_data`  out  32  load data; valid when `rd_req`=1 and `rw_wait`=0.
- `rw_wait`  out  1  stall to the Memory stage.
- `mem_addr`  out  32  external address.
- `mem_rd`  out  1  external read strobe; held until `mem_ack`.
- `mem_wr`  out  1  external write strobe; held until `mem_ack`.
- `mem_wdata`  out  32  external write data.
- `mem_rdata`  in  32  external read data; valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle transfer completion; may be asserted in the first cycle of a strobe.
- `wb_empty`  out  1  write buffer empty.

## Operation
- **FSM states:** IDLE, DRAIN, RDREQ, RDDONE.
- **IDLE:**
  - `rd_req`: latch `busaddr` into `raddr`. Go to RDREQ if the buffer is empty, otherwise DRAIN.
  - `wr_req` with count<`WB_DEPTH`: push {`busaddr`,`wr_data`} this edge.
  - `wr_req` with buffer full: no push.
  - `rd_req` and `wr_req` both high is illegal; it is treated as a read and the write is ignored.
- **DRAIN:** go to RDREQ on the edge where the buffer becomes empty.
- **RDREQ:**
  - `mem_rd`=1, `mem_addr`=`raddr`.
  - On `mem_ack`: capture `mem_rdata` into `rd_data`, go to RDDONE.
- **RDDONE:** `rw_wait`=0 for exactly one cycle; unconditionally return to IDLE.
- **`rw_wait`** (combinational):
  - IDLE: `rd_req` | (`wr_req` & full).
  - DRAIN and RDREQ: 1.
  - RDDONE: 0.
- **Write drain:**
  - `mem_wr` = buffer non-empty and state ≠ RDREQ.
  - `mem_addr`/`mem_wdata` come from the buffer head.
  - Pop on `mem_ack` while `mem_wr`=1.
  - Drain runs in any state other than RDREQ. `mem_rd` and `mem_wr` are never both 1.
- **External outputs** are driven only from registers and state, never combinationally from inputs.
- **Requests outside IDLE:** `wr_req` is ignored in DRAIN, RDREQ and RDDONE (the stage is stalled there); a newly asserted `rd_req` in RDDONE is not a new request.
- **Full buffer:**
  - Fullness is judged from the registered count.
  - A pop in the same cycle does not admit the stalled write; that write is accepted the next cycle.
  - A push and a pop in the same cycle leave the count unchanged.
- **Pointers:** `log2(WB_DEPTH)` bits, wrapping modulo `WB_DEPTH`.
- **Count:** `log2(WB_DEPTH)`+1 bits.

## Timing
- **Reset** (asynchronous, immediate), state and outputs:
  - state IDLE, count 0, pointers 0, buffered writes discarded;
  - `rd_data`=0, `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `wb_empty`=1;
  - `rw_wait` = `rd_req` while in reset.
- **Reset mid-transfer:** strobes drop at once; a pending read is abandoned.
- **Load, empty buffer, zero-wait memory:**
  - cycle 0 IDLE, `rw_wait`=1;
  - cycle 1 RDREQ, `mem_rd`=1, `mem_ack`=1;
  - cycle 2 RDDONE, `rw_wait`=0, data valid.
  - Load latency is 3 cycles plus memory wait cycles plus drain time.
- **Store, buffer not full:** `rw_wait`=0 in the request cycle; `mem_wr` is asserted from the next cycle.
- **Throughput:** one external transfer per cycle at most.

## Structure
- Local localparams hold the FSM encodings; nothing is added to the shared constants include.
- One sub-module, `wb_fifo`:
  - parameterised synchronous FIFO of {addr, data} entries;
  - push, pop, head, count, full, empty;
  - async active-low reset.
- `dbus_ctrl` contains the FSM, `raddr`/`rd_data` registers and output muxing.

## Test plan
- **Reset:** assert `Nrst`=0 mid-read (in RDREQ) → `mem_rd` drops immediately, `wb_empty`=1, state IDLE after release.
- **Single store:** store 0x100←0xDEADBEEF, zero-wait memory → `rw_wait`=0 in the request cycle; next cycle `mem_wr`=1, `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF; `wb_empty`=1 after the ack.
- **Buffer full:** 5 back-to-back stores with `mem_ack` held low → the first 4 are accepted, the 5th sees `rw_wait`=1 until the cycle after the first ack.
- **Load after stores:** stores to 0x200 and 0x204, then a load of 0x204 → `mem_rd` is never asserted before both writes are acked; load returns the memory-model value written (0x204 data).
- **Load, wait states:** load 0x300 with a 3-cycle ack delay and `mem_rdata`=0x12345678 → `rw_wait` high for 5 cycles, low for 1 cycle with `rd_data`=0x12345678.
- **Pointer wrap:** 10 stores with random ack delays → the external write sequence matches the request order exactly and the pointers wrap correctly.
